// File: rtl/axi4lite_pkg.sv
// Shared AXI4-lite definitions: response codes, master FSM states and the
// bit positions of the fields packed into command/response FIFO words.
package axi4lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_B,
    ST_RD,
    ST_RD_R,
    ST_PUSH
  } state_e;

  // cmd word = {is_write, addr, data}: is_write sits above addr and data
  function automatic int cmd_wr_bit(int aw, int dw);
    return aw + dw;
  endfunction

  // rsp word = {was_write, resp[1:0], rdata}
  function automatic int rsp_wr_bit(int dw);
    return dw + 2;
  endfunction

  function automatic int rsp_resp_lsb(int dw);
    return dw;
  endfunction

  // Anything other than OKAY (including EXOKAY) is counted as an error
  function automatic logic resp_is_err(logic [1:0] r);
    return r != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi4lite_master.sv
// AXI4-lite initiator: pops one command, runs it as a single serial read or
// write transaction, and pushes the result into the response FIFO.
module axi4lite_master
  import axi4lite_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int PUSH_WR_RSP = 1,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [ADDR_W+DATA_W:0]   cmd_data,
  input  logic                     cmd_empty,
  output logic                     cmd_read_en,
  output logic [DATA_W+2:0]        rsp_data,
  output logic                     rsp_write_en,
  input  logic                     rsp_full,
  output logic [ADDR_W-1:0]        awaddr,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [DATA_W-1:0]        wdata,
  output logic                     wvalid,
  input  logic                     wready,
  input  logic [1:0]               bresp,
  input  logic                     bvalid,
  output logic                     bready,
  output logic [ADDR_W-1:0]        araddr,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [DATA_W-1:0]        rdata,
  input  logic [1:0]               rresp,
  input  logic                     rvalid,
  output logic                     rready,
  output logic                     busy,
  output logic [ERR_CNT_W-1:0]     err_count
);

  localparam int CMD_WR   = cmd_wr_bit(ADDR_W, DATA_W);
  localparam int RSP_WR   = rsp_wr_bit(DATA_W);
  localparam int RSP_RESP = rsp_resp_lsb(DATA_W);

  state_e                 state_q;
  logic                   awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic [ADDR_W-1:0]      awaddr_q, araddr_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [DATA_W+2:0]      rsp_q;
  logic [ERR_CNT_W-1:0]   err_q, err_d;
  logic                   b_fire, r_fire, err_hit;

  // bready/rready are held high for the whole WR_B/RD_R state, so the
  // response handshake is just the slave's valid while in that state.
  assign b_fire  = (state_q == ST_WR_B) && bvalid;
  assign r_fire  = (state_q == ST_RD_R) && rvalid;
  assign err_hit = (b_fire && resp_is_err(bresp)) || (r_fire && resp_is_err(rresp));

  // Pop is gated by reset so nothing is consumed while the FSM is held
  assign cmd_read_en  = (state_q == ST_IDLE) && !cmd_empty && !areset;
  assign rsp_write_en = (state_q == ST_PUSH) && !rsp_full;
  assign busy         = (state_q != ST_IDLE);

  assign awaddr    = awaddr_q;
  assign awvalid   = awvalid_q;
  assign wdata     = wdata_q;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;
  assign araddr    = araddr_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
  assign rsp_data  = rsp_q;
  assign err_count = err_q;

  // Transaction FSM with registered channel controls and capture registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= ST_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      araddr_q  <= '0;
      rsp_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!cmd_empty) begin
            if (cmd_data[CMD_WR]) begin
              awaddr_q  <= cmd_data[ADDR_W+DATA_W-1:DATA_W];
              wdata_q   <= cmd_data[DATA_W-1:0];
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= ST_WR;
            end else begin
              araddr_q  <= cmd_data[ADDR_W+DATA_W-1:DATA_W];
              arvalid_q <= 1'b1;
              state_q   <= ST_RD;
            end
          end
        end
        ST_WR: begin
          // A dropped valid doubles as that channel's "done" flag
          if (awready) awvalid_q <= 1'b0;
          if (wready)  wvalid_q  <= 1'b0;
          if ((!awvalid_q || awready) && (!wvalid_q || wready)) begin
            bready_q <= 1'b1;
            state_q  <= ST_WR_B;
          end
        end
        ST_WR_B: begin
          if (bvalid) begin
            bready_q               <= 1'b0;
            rsp_q[RSP_WR]          <= 1'b1;
            rsp_q[RSP_RESP +: 2]   <= bresp;
            rsp_q[DATA_W-1:0]      <= '0;
            state_q                <= (PUSH_WR_RSP != 0) ? ST_PUSH : ST_IDLE;
          end
        end
        ST_RD: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD_R;
          end
        end
        ST_RD_R: begin
          if (rvalid) begin
            rready_q               <= 1'b0;
            rsp_q[RSP_WR]          <= 1'b0;
            rsp_q[RSP_RESP +: 2]   <= rresp;
            rsp_q[DATA_W-1:0]      <= rdata;
            state_q                <= ST_PUSH;
          end
        end
        ST_PUSH: begin
          if (!rsp_full) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Saturating count of non-OKAY responses
  always_comb begin
    err_d = err_q;
    if (err_hit && (err_q != '1)) err_d = err_q + 1'b1;
  end

  // Error counter register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) err_q <= '0;
    else        err_q <= err_d;
  end

endmodule
